mux_2_x_1_rr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer that shares one 2:1 mux datapath between two requesters (A, B).

---
 rtl/mux_2_x_1_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux_2_x_1_rr_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_2_x_1_rr_arbiter.sv
// Round-robin arbiter that shares a single 2:1 mux datapath between two
// requesters (A and B) and presents the muxed data as a valid/ready stream.
// A grant is held for up to MAX_HOLD completed transfers while the other side
// is waiting. When only one side requests, that side keeps the grant.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_a      requester A has data on in_a
//   req_b      requester B has data on in_b
//   in_a       data from A
//   in_b       data from B
//   out_ready  consumer accepts m_out this cycle
//   select     registered mux select (1 = in_a, 0 = in_b)
//   grant_a    A currently owns the mux (registered)
//   grant_b    B currently owns the mux (registered)
//   out_valid  m_out carries valid data this cycle
//   m_out      muxed data
module mux_2_x_1_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             out_ready,
  output logic             select,
  output logic             grant_a,
  output logic             grant_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] m_out
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B
  } state_e;

  state_e        state_q, state_d;
  logic          select_q, select_d;
  logic          last_a_q, last_a_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          xfer;
  logic          quota_done;

  assign grant_a   = (state_q == GNT_A);
  assign grant_b   = (state_q == GNT_B);
  assign select    = select_q;
  assign out_valid = (grant_a & req_a) | (grant_b & req_b);
  assign m_out     = select_q ? in_a : in_b;
  assign xfer      = out_valid & out_ready;

  // Quota is used up either by the transfer completing this cycle or because
  // the counter already saturated while the other side was not requesting.
  assign quota_done = (xfer && (hold_cnt_q == HOLD_LAST)) || (hold_cnt_q == HOLD_MAX);

  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    last_a_d   = last_a_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_a && !req_b)      state_d = GNT_A;
        else if (!req_a && req_b) state_d = GNT_B;
        else if (req_a && req_b)  state_d = last_a_q ? GNT_B : GNT_A;
      end
      GNT_A: begin
        if (!req_a)                        state_d = req_b ? GNT_B : IDLE;
        else if (req_b && quota_done)      state_d = GNT_B;
      end
      GNT_B: begin
        if (!req_b)                        state_d = req_a ? GNT_A : IDLE;
        else if (req_a && quota_done)      state_d = GNT_A;
      end
      default: state_d = IDLE;
    endcase

    // select and last_a only move on a grant; IDLE keeps the previous select.
    if (state_d == GNT_A) begin
      select_d = 1'b1;
      last_a_d = 1'b1;
    end else if (state_d == GNT_B) begin
      select_d = 1'b0;
      last_a_d = 1'b0;
    end

    if (state_d != state_q)                 hold_cnt_d = '0;
    else if (xfer && hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      select_q   <= 1'b1;
      last_a_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      last_a_q   <= last_a_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_2_x_1_rr_arbiter.sv
module tb_mux_2_x_1_rr_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned MH = 4;

  logic         clk;
  logic         reset;
  logic         req_a, req_b;
  logic [W-1:0] in_a, in_b;
  logic         out_ready;
  logic         select, grant_a, grant_b, out_valid;
  logic [W-1:0] m_out;

  int checks   = 0;
  int failures = 0;

  mux_2_x_1_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_ready(out_ready),
    .select   (select),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .out_valid(out_valid),
    .m_out    (m_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: owner (0 none, 1 A, 2 B), number of transfers completed
  // in the current grant, which side was granted last, and the mux select.
  int m_owner = 0;
  int m_cnt   = 0;
  bit m_last_a = 0;
  bit m_sel    = 1;
  bit m_ok     = 0;

  function automatic int exp_valid();
    return ((m_owner == 1 && req_a) || (m_owner == 2 && req_b)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_owner = 0; m_cnt = 0; m_last_a = 0; m_sel = 1; m_ok = 1;
    end else if (m_ok) begin
      int nxt;
      bit xf;
      bit mine, other;
      xf  = exp_valid() && out_ready;
      nxt = m_owner;
      if (m_owner == 0) begin
        if (req_a && req_b) nxt = m_last_a ? 2 : 1;
        else if (req_a)     nxt = 1;
        else if (req_b)     nxt = 2;
      end else begin
        mine  = (m_owner == 1) ? req_a : req_b;
        other = (m_owner == 1) ? req_b : req_a;
        // Hand over once the quota (including this transfer) is exhausted.
        if (!mine)                                  nxt = other ? 3 - m_owner : 0;
        else if (other && (m_cnt + int'(xf) >= MH)) nxt = 3 - m_owner;
      end
      if (nxt != m_owner) m_cnt = 0;
      else if (xf)        m_cnt = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
      if (nxt == 1) begin m_sel = 1; m_last_a = 1; end
      if (nxt == 2) begin m_sel = 0; m_last_a = 0; end
      m_owner = nxt;
    end
  end

  // Single compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    #2;
    if (m_ok) begin
      chk("grant_a",   int'(grant_a),   int'(m_owner == 1));
      chk("grant_b",   int'(grant_b),   int'(m_owner == 2));
      chk("select",    int'(select),    int'(m_sel));
      chk("out_valid", int'(out_valid), exp_valid());
      chk("m_out",     int'(m_out),     m_sel ? int'(in_a) : int'(in_b));
    end
  end

  task automatic drive(input logic rst, input logic ra, input logic rb,
                       input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic rdy);
    @(negedge clk);
    reset = rst; req_a = ra; req_b = rb; in_a = ia; in_b = ib; out_ready = rdy;
    #3;
  endtask

  // Current transfer owner as seen on the outputs: 0 none, 1 A, 2 B.
  function automatic int xfer_owner();
    if (!(out_valid && out_ready)) return 0;
    return grant_a ? 1 : 2;
  endfunction

  initial begin
    int exp_seq [9];
    exp_seq = '{1, 1, 1, 1, 2, 2, 2, 2, 1};

    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    in_a = 4'h5; in_b = 4'hA; out_ready = 1'b1;

    // Reset held two cycles with both requesting.
    drive(1, 1, 1, 4'h5, 4'hA, 1);
    chk("rst_grant_a",   int'(grant_a),   0);
    chk("rst_grant_b",   int'(grant_b),   0);
    chk("rst_select",    int'(select),    1);
    chk("rst_out_valid", int'(out_valid), 0);
    drive(0, 1, 1, 4'h5, 4'hA, 1);
    chk("rel_grant_a_0", int'(grant_a), 0);

    // Both requesting, full throughput: A x4, B x4, A.
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 1, 4'(i), 4'(15 - i), 1);
      chk($sformatf("rr_seq_%0d", i), xfer_owner(), exp_seq[i]);
    end

    // Backpressure for 6 cycles: A holds, count frozen at 1.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 4'h3, 4'hC, 0);
      chk($sformatf("bp_grant_a_%0d", i), int'(grant_a), 1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 4'h3, 4'hC, 1);
      chk($sformatf("bp_resume_%0d", i), xfer_owner(), (i < 3) ? 1 : 2);
    end

    // B owns; B drops while A requests, then A drops while B requests.
    drive(0, 1, 0, 4'h1, 4'h2, 1);
    chk("b_drop_valid", int'(out_valid), 0);
    drive(0, 0, 1, 4'h1, 4'h2, 1);
    chk("a_took_grant", int'(grant_a), 1);
    drive(0, 0, 1, 4'h1, 4'h1, 1);
    chk("direct_grant_b", int'(grant_b), 1);
    chk("direct_select",  int'(select),  0);

    // Single requester B keeps the grant well beyond MAX_HOLD.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 4'h0, 4'h1, 1);
      chk($sformatf("solo_b_%0d", i), xfer_owner(), 2);
      chk($sformatf("solo_mout_%0d", i), int'(m_out), 1);
    end

    // Two A transfers, then reset mid-burst.
    drive(0, 1, 0, 4'h7, 4'h8, 1);
    drive(0, 1, 1, 4'h7, 4'h8, 1);
    chk("pre_rst_x1", xfer_owner(), 1);
    drive(0, 1, 1, 4'h7, 4'h8, 1);
    chk("pre_rst_x2", xfer_owner(), 1);
    drive(1, 1, 1, 4'h7, 4'h8, 1);
    drive(0, 1, 1, 4'h7, 4'h8, 1);
    chk("mid_rst_idle",  int'(grant_a),   0);
    chk("mid_rst_valid", int'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 4'h7, 4'h8, 1);
      chk($sformatf("post_rst_%0d", i), xfer_owner(), (i < 4) ? 1 : 2);
    end

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
